// File: rtl/seg7_mux_driver_if.sv
// Display-side bundle for seg7_mux_driver: datapath inputs, the pins it drives, and the scan FSM state.
// load is a single-cycle strobe with no backpressure: the driver always accepts it on the edge where it is high.
interface seg7_mux_driver_if #(
    parameter int DIGITS = 4,
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1
);
    logic                  enable;
    logic                  load;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     dp_in;
    logic                  blank_lz;
    logic [6:0]            seg;
    logic                  dp;
    logic [DIGITS-1:0]     an;
    logic [IW-1:0]         digit_idx;
    logic [1:0]            fsm_state;

    modport master (
        output enable, load, value, dp_in, blank_lz,
        input  seg, dp, an, digit_idx, fsm_state
    );

    modport slave (
        input  enable, load, value, dp_in, blank_lz,
        output seg, dp, an, digit_idx, fsm_state
    );
endinterface

// File: rtl/seg7_mux_driver.sv
// Time-multiplexed 7-segment driver: shadowed hex value, prescaled digit scan with a
// one-cycle all-off guard between digits, leading-zero blanking and per-digit decimal points.
module seg7_mux_driver #(
    parameter int DIGITS         = 4,
    parameter int REFRESH_DIV    = 100000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1,
    localparam int PW = $clog2(REFRESH_DIV)
) (
    input logic clk,
    input logic rst,
    seg7_mux_driver_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, GUARD = 2'd2} state_t;

    localparam logic [6:0]        SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic              DP_OFF  = SEG_ACTIVE_LOW;
    localparam logic [DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    state_t              state_q, state_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] shadow_value;
    logic [DIGITS-1:0]   shadow_dp;
    logic                shadow_blank;
    logic [DIGITS-1:0]   blank_mask;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [3:0]          nib;

    function automatic logic [6:0] decode(input logic [3:0] code);
        case (code)
            4'h0: decode = 7'h7E;  4'h1: decode = 7'h30;
            4'h2: decode = 7'h6D;  4'h3: decode = 7'h79;
            4'h4: decode = 7'h33;  4'h5: decode = 7'h5B;
            4'h6: decode = 7'h5F;  4'h7: decode = 7'h70;
            4'h8: decode = 7'h7F;  4'h9: decode = 7'h7B;
            4'hA: decode = 7'h77;  4'hB: decode = 7'h1F;
            4'hC: decode = 7'h4E;  4'hD: decode = 7'h3D;
            4'hE: decode = 7'h4F;  default: decode = 7'h47;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            presc_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        idx_d   = idx_q;
        if (!bus.enable) begin
            state_d = IDLE;
            presc_d = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ACTIVE;
                    presc_d = '0;
                    idx_d   = '0;
                end
                ACTIVE: begin
                    if (presc_q == PW'(REFRESH_DIV - 1)) begin
                        state_d = GUARD;
                        presc_d = '0;
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                GUARD: begin
                    state_d = ACTIVE;
                    presc_d = '0;
                    idx_d   = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
                end
                default: begin
                    state_d = IDLE;
                    presc_d = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_value <= '0;
            shadow_dp    <= '0;
            shadow_blank <= 1'b0;
        end else if (bus.load) begin
            shadow_value <= bus.value;
            shadow_dp    <= bus.dp_in;
            shadow_blank <= bus.blank_lz;
        end
    end

    // A digit is a leading zero when it and every more-significant nibble are zero.
    always_comb begin
        logic zero_above;
        blank_mask = '0;
        zero_above = shadow_blank;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above    = zero_above && (shadow_value[4*i +: 4] == 4'h0);
            blank_mask[i] = zero_above;
        end
    end

    // Outputs are derived from the next state so the registered pins line up with state_q/idx_q.
    always_comb begin
        nib  = shadow_value[4*int'(idx_d) +: 4];
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        dp_d  = DP_OFF;
        if (state_d == ACTIVE) begin
            an_d = (DIGITS'(1) << idx_d) ^ AN_OFF;
            dp_d = shadow_dp[idx_d] ^ DP_OFF;
            if (!blank_mask[idx_d]) begin
                seg_d = decode(nib) ^ SEG_OFF;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q <= SEG_OFF;
            dp_q  <= DP_OFF;
            an_q  <= AN_OFF;
        end else begin
            seg_q <= seg_d;
            dp_q  <= dp_d;
            an_q  <= an_d;
        end
    end

    assign bus.seg       = seg_q;
    assign bus.dp        = dp_q;
    assign bus.an        = an_q;
    assign bus.digit_idx = idx_q;
    assign bus.fsm_state = state_q;
endmodule

// File: tb/tb_seg7_mux_driver.sv
// Bench for seg7_mux_driver (4 digits, refresh 4, active-low pins): a frame-position model
// checked every cycle, plus directed scenarios with hand-computed pin values.
module tb_seg7_mux_driver;
    localparam int DIGITS = 4;
    localparam int DIV    = 4;
    localparam int SLOT   = DIV + 1;
    localparam int FRAME  = DIGITS * SLOT;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    seg7_mux_driver_if #(.DIGITS(DIGITS)) bus ();

    seg7_mux_driver #(
        .DIGITS(DIGITS), .REFRESH_DIV(DIV), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Active-high segment patterns for codes 0..F.
    logic [6:0] pat [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                             7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    // Model state: k = number of consecutive enabled edges since the display was last off.
    int          m_k;
    logic [15:0] m_val;
    logic [3:0]  m_dp;
    logic        m_blank;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [3:0]  e_an;
    logic [1:0]  e_idx;

    task automatic model_out(input int k, input logic [15:0] val, input logic [3:0] dpv,
                             input logic blank, output logic [6:0] s, output logic d,
                             output logic [3:0] a, output logic [1:0] idx);
        int p, dig;
        logic lit, blanked;
        p   = (k > 0) ? (k - 1) % FRAME : 0;
        dig = p / SLOT;
        lit = (k > 0) && (p % SLOT != DIV);
        blanked = blank && dig > 0 && ((val >> (4 * dig)) == 16'h0);
        idx = (k > 0) ? 2'(dig) : 2'd0;
        a   = lit ? ~(4'b0001 << dig) : 4'hF;
        d   = lit ? ~dpv[dig] : 1'b1;
        s   = (lit && !blanked) ? ~pat[(val >> (4 * dig)) & 16'hF] : 7'h7F;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_k     <= 0;
            m_val   <= '0;
            m_dp    <= '0;
            m_blank <= 1'b0;
            e_seg   <= 7'h7F;
            e_dp    <= 1'b1;
            e_an    <= 4'hF;
            e_idx   <= 2'd0;
        end else begin
            int kn;
            logic [6:0] s;
            logic d;
            logic [3:0] a;
            logic [1:0] idx;
            kn = bus.enable ? m_k + 1 : 0;
            model_out(kn, m_val, m_dp, m_blank, s, d, a, idx);
            m_k   <= kn;
            e_seg <= s;
            e_dp  <= d;
            e_an  <= a;
            e_idx <= idx;
            if (bus.load) begin
                m_val   <= bus.value;
                m_dp    <= bus.dp_in;
                m_blank <= bus.blank_lz;
            end
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("model_seg", 16'(bus.seg), 16'(e_seg));
            check("model_dp", 16'(bus.dp), 16'(e_dp));
            check("model_an", 16'(bus.an), 16'(e_an));
            check("model_idx", 16'(bus.digit_idx), 16'(e_idx));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_an(input logic [3:0] target);
        for (int i = 0; i < 3 * FRAME; i++) begin
            if (bus.an === target) return;
            @(negedge clk);
        end
        check("wait_an_timeout", 16'(bus.an), 16'(target));
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic b);
        bus.value    = v;
        bus.dp_in    = d;
        bus.blank_lz = b;
        bus.load     = 1'b1;
        step(1);
        bus.load     = 1'b0;
    endtask

    task automatic check_digit(input string name, input logic [3:0] a,
                               input logic [6:0] s, input logic d);
        wait_an(a);
        check({name, "_seg"}, 16'(bus.seg), 16'(s));
        check({name, "_dp"}, 16'(bus.dp), 16'(d));
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        bus.enable = 1'b0;
        bus.load = 1'b0;
        bus.value = '0;
        bus.dp_in = '0;
        bus.blank_lz = 1'b0;
        step(2);
        rst = 1'b0;

        // Idle after reset: everything off for 20 cycles.
        for (int i = 0; i < 20; i++) begin
            step(1);
            check("idle_pins", {bus.seg, bus.dp, bus.an, bus.digit_idx}, {7'h7F, 1'b1, 4'hF, 2'd0});
        end

        // Plain hex scan of 12AF.
        do_load(16'h12AF, 4'b0000, 1'b0);
        bus.enable = 1'b1;
        check_digit("d0_F", 4'hE, 7'h38, 1'b1);
        check("d0_idx", 16'(bus.digit_idx), 16'd0);
        check_digit("d1_A", 4'hD, 7'h08, 1'b1);
        check_digit("d2_2", 4'hB, 7'h12, 1'b1);
        check_digit("d3_1", 4'h7, 7'h4F, 1'b1);
        step(DIV);
        check("guard_an", 16'(bus.an), 16'hF);
        check("guard_seg", 16'(bus.seg), 16'h7F);
        step(1);
        check("wrap_an", 16'(bus.an), 16'hE);
        check("wrap_idx", 16'(bus.digit_idx), 16'd0);

        // Leading-zero blanking with a decimal point on a blanked digit.
        do_load(16'h0070, 4'b0100, 1'b1);
        step(2);
        wait_an(4'hF);
        check_digit("lz_d3", 4'h7, 7'h7F, 1'b1);
        check_digit("lz_d2", 4'hB, 7'h7F, 1'b0);
        check_digit("lz_d1", 4'hD, 7'h0F, 1'b1);
        check_digit("lz_d0", 4'hE, 7'h01, 1'b1);

        // All zeros: only digit 0 shows a glyph.
        do_load(16'h0000, 4'b0000, 1'b1);
        step(2);
        wait_an(4'hF);
        check_digit("z_d3", 4'h7, 7'h7F, 1'b1);
        check_digit("z_d2", 4'hB, 7'h7F, 1'b1);
        check_digit("z_d1", 4'hD, 7'h7F, 1'b1);
        check_digit("z_d0", 4'hE, 7'h01, 1'b1);

        // Mid-slot load while digit 2 is lit.
        wait_an(4'hB);
        do_load(16'h8888, 4'b0000, 1'b0);
        check("ml_old_seg", 16'(bus.seg), 16'h7F);
        check("ml_old_an", 16'(bus.an), 16'hB);
        step(1);
        check("ml_new_seg", 16'(bus.seg), 16'h00);
        check("ml_new_an", 16'(bus.an), 16'hB);
        check("ml_new_idx", 16'(bus.digit_idx), 16'd2);

        // Disable mid-slot.
        wait_an(4'hE);
        step(1);
        bus.enable = 1'b0;
        step(1);
        check("dis_pins", {bus.seg, bus.dp, bus.an, bus.digit_idx}, {7'h7F, 1'b1, 4'hF, 2'd0});

        // Asynchronous reset mid-slot.
        bus.enable = 1'b1;
        wait_an(4'hD);
        #1 rst = 1'b1;
        #1;
        check("arst_pins", {bus.seg, bus.dp, bus.an, bus.digit_idx}, {7'h7F, 1'b1, 4'hF, 2'd0});
        step(1);
        rst = 1'b0;
        check_digit("post_rst_d0", 4'hE, 7'h01, 1'b1);
        step(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
